// File: rtl/fpu_issue_ctrl.sv
// Two-requester issue controller in front of a shared combinational FPU, treated as a multicycle path.
// Define FPU_CTRL_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
package ibex_pkg;
  typedef enum logic [1:0] {
    FP_ALU_ADD = 2'd0,
    FP_ALU_SUB = 2'd1,
    FP_ALU_MUL = 2'd2
  } fp_alu_op_e;
endpackage

module fpu_issue_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned ADDSUB_CYCLES = 1,
  parameter int unsigned MUL_CYCLES    = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  fp_alu_op_e [1:0] req_op_i,
  input  logic [1:0][15:0] req_a_i,
  input  logic [1:0][15:0] req_b_i,
  output logic [1:0]       rsp_valid_o,
  input  logic [1:0]       rsp_ready_i,
  output logic [15:0]      rsp_result_o,
  output fp_alu_op_e       fpu_operator_o,
  output logic [15:0]      fpu_operand_a_o,
  output logic [15:0]      fpu_operand_b_o,
  input  logic [15:0]      fpu_result_i,
  output logic             busy_o
);

  if (ADDSUB_CYCLES < 1 || ADDSUB_CYCLES > 15) begin : g_bad_addsub
    $error("ADDSUB_CYCLES must be in 1..15");
  end
  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul
    $error("MUL_CYCLES must be in 1..15");
  end

  localparam logic [3:0] ADD_LOAD = 4'(ADDSUB_CYCLES - 1);
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        grant_q, grant_d;
  fp_alu_op_e  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] result_q, result_d;
  logic        win;

`ifdef FPU_CTRL_FIXED_PRIO_EN
  assign win = ~req_valid_i[0];
`else
  logic last_grant_q, last_grant_d;

  // On a tie the requester not served last time wins; otherwise the sole requester wins.
  assign win = (&req_valid_i) ? ~last_grant_q : ~req_valid_i[0];
  assign last_grant_d = (state_q == IDLE && (|req_valid_i)) ? win : last_grant_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      grant_q  <= 1'b0;
      op_q     <= FP_ALU_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    unique case (state_q)
      IDLE: begin
        // Ready is gated by reset so nothing looks accepted while the flops are held.
        if ((|req_valid_i) && rst_ni) begin
          req_ready_o[win] = 1'b1;
          grant_d          = win;
          op_d             = req_op_i[win];
          a_d              = req_a_i[win];
          b_d              = req_b_i[win];
          cnt_d            = (req_op_i[win] == FP_ALU_ADD || req_op_i[win] == FP_ALU_SUB)
                             ? ADD_LOAD : MUL_LOAD;
          state_d          = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d = fpu_result_i;
          state_d  = RESP;
        end
      end
      RESP: begin
        rsp_valid_o[grant_q] = 1'b1;
        if (rsp_ready_i[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fpu_operator_o  = op_q;
  assign fpu_operand_a_o = a_q;
  assign fpu_operand_b_o = b_q;
  assign rsp_result_o    = result_q;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl with a bfloat16 reference FPU driving fpu_result_i.
module tb_fpu_issue_ctrl;
  import ibex_pkg::*;

  localparam int ADD_N = 1;
  localparam int MUL_N = 2;

  typedef struct {
    fp_alu_op_e  op;
    logic [15:0] a, b, res;
  } op_t;

  typedef struct {
    int          idx;
    logic [15:0] res, a, b;
    fp_alu_op_e  op;
    int          n;
    int          acc;
  } sb_t;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  fp_alu_op_e [1:0] req_op;
  logic [1:0][15:0] req_a, req_b;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [15:0]      rsp_result;
  fp_alu_op_e       fpu_op;
  logic [15:0]      fpu_a, fpu_b, fpu_res;
  logic             busy;

  op_t pend0[$], pend1[$];
  op_t cur[2];
  sb_t sb[$];
  int  glog[$];
  int  model_last = 1;
  int  cyc = 0;
  int  n_vec = 0, n_err = 0;

  fpu_issue_ctrl #(.ADDSUB_CYCLES(ADD_N), .MUL_CYCLES(MUL_N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .fpu_operator_o(fpu_op), .fpu_operand_a_o(fpu_a), .fpu_operand_b_o(fpu_b),
    .fpu_result_i(fpu_res), .busy_o(busy)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic real bf2r(input logic [15:0] h);
    logic [63:0] d;
    if (h[14:0] == 15'd0) return 0.0;
    d = {h[15], 11'({3'b000, h[14:7]} + 11'd896), h[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52];
    if (e == 11'd0) return 16'h0000;
    return {d[63], 8'(e - 11'd896), d[51:45]};
  endfunction

  function automatic logic [15:0] fpu_ref(input fp_alu_op_e op, input logic [15:0] a, b);
    case (op)
      FP_ALU_ADD: return r2bf(bf2r(a) + bf2r(b));
      FP_ALU_SUB: return r2bf(bf2r(a) - bf2r(b));
      default:    return r2bf(bf2r(a) * bf2r(b));
    endcase
  endfunction

  assign fpu_res = fpu_ref(fpu_op, fpu_a, fpu_b);

  function automatic logic [1:0] exp_ready(input logic [1:0] v, input int last);
    case (v)
      2'b00:   return 2'b00;
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
`ifdef FPU_CTRL_FIXED_PRIO_EN
      default: return 2'b01;
`else
      default: return (last != 0) ? 2'b01 : 2'b10;
`endif
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push(input int r, input fp_alu_op_e op, input logic [15:0] a, b, res);
    op_t o;
    o.op = op; o.a = a; o.b = b; o.res = res;
    if (r == 0) pend0.push_back(o);
    else pend1.push_back(o);
  endtask

  task automatic chk_reset();
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_result", rsp_result, 16'h0);
    check("rst_fpu_op", fpu_op, FP_ALU_ADD);
    check("rst_fpu_a", fpu_a, 16'h0);
    check("rst_fpu_b", fpu_b, 16'h0);
    check("rst_busy", busy, 1'b0);
  endtask

  task automatic wait_drain(input int budget, input bit rnd);
    int t = 0;
    int left;
    while ((pend0.size() + pend1.size() + sb.size() != 0 || (|req_valid) || busy) && t < budget) begin
      step(1);
      t++;
      if (rnd) rsp_ready = 2'($urandom);
    end
    rsp_ready = 2'b11;
    left = pend0.size() + pend1.size() + sb.size() + int'(busy) + int'(|req_valid);
    check("drain_left", left, 0);
  endtask

  // Requester agents: hold each request until accepted, then present the next queued one.
  initial begin
    bit [1:0] acc;
    forever begin
      @(negedge clk_i);
      acc = rst_ni ? (req_valid & req_ready) : 2'b00;
      @(posedge clk_i);
      #1;
      for (int r = 0; r < 2; r++) begin
        if (acc[r] || !req_valid[r]) begin
          req_valid[r] = 1'b0;
          if (r == 0 && pend0.size() > 0) begin
            cur[0] = pend0.pop_front();
            req_valid[0] = 1'b1;
          end else if (r == 1 && pend1.size() > 0) begin
            cur[1] = pend1.pop_front();
            req_valid[1] = 1'b1;
          end
          if (req_valid[r]) begin
            req_op[r] = cur[r].op; req_a[r] = cur[r].a; req_b[r] = cur[r].b;
          end
        end
      end
    end
  end

  // Monitor: handshake rules, FPU input stability, latency and scoreboard.
  initial begin
    bit          bprev, rprev;
    logic [15:0] pa, pb, pres;
    fp_alu_op_e  pop;
    logic [1:0]  acc;
    int          g;
    sb_t         e;
    bprev = 0; rprev = 0; pa = 0; pb = 0; pres = 0; pop = FP_ALU_ADD;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        bprev = 0;
        rprev = 0;
      end else begin
        check("req_ready", req_ready, (sb.size() != 0) ? 2'b00 : exp_ready(req_valid, model_last));
        check("busy", busy, sb.size() != 0);
        acc = req_valid & req_ready;
        if (|acc) begin
          g = acc[1] ? 1 : 0;
          e.idx = g; e.res = cur[g].res; e.a = cur[g].a; e.b = cur[g].b; e.op = cur[g].op;
          e.n = (cur[g].op == FP_ALU_ADD || cur[g].op == FP_ALU_SUB) ? ADD_N : MUL_N;
          e.acc = cyc + 1;
          sb.push_back(e);
          glog.push_back(g);
          model_last = g;
        end
        if (busy && sb.size() > 0) begin
          if (!bprev) begin
            check("fpu_a_latched", fpu_a, sb[0].a);
            check("fpu_b_latched", fpu_b, sb[0].b);
            check("fpu_op_latched", fpu_op, sb[0].op);
          end else begin
            check("fpu_a_stable", fpu_a, pa);
            check("fpu_b_stable", fpu_b, pb);
            check("fpu_op_stable", fpu_op, pop);
          end
        end
        bprev = busy; pa = fpu_a; pb = fpu_b; pop = fpu_op;
        if (|rsp_valid) begin
          if (sb.size() == 0) begin
            check("spurious_rsp", rsp_valid, 2'b00);
          end else begin
            if (!rprev) begin
              check("latency", cyc - sb[0].acc, sb[0].n);
              check("rsp_idx", rsp_valid, 2'b01 << sb[0].idx);
            end else begin
              check("rsp_hold", rsp_result, pres);
            end
            if (|(rsp_valid & rsp_ready)) begin
              e = sb.pop_front();
              check("result", rsp_result, e.res);
              $display("rsp req%0d op=%0d a=%h b=%h result=%h", e.idx, e.op, e.a, e.b, rsp_result);
            end
          end
        end
        rprev = (|rsp_valid) && !(|(rsp_valid & rsp_ready));
        pres = rsp_result;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_ord[4];
    int t;
    fp_alu_op_e op;
    logic [15:0] a, b;
`ifdef FPU_CTRL_FIXED_PRIO_EN
    exp_ord = '{0, 0, 0, 0};
`else
    exp_ord = '{0, 1, 0, 1};
`endif
    rst_ni = 1'b0;
    req_valid = 2'b00;
    req_op = {FP_ALU_ADD, FP_ALU_ADD};
    req_a = '0;
    req_b = '0;
    rsp_ready = 2'b11;

    // Both requesters valid from reset with SUB 3.0-1.0.
    for (int i = 0; i < 4; i++) begin
      push(0, FP_ALU_SUB, 16'h4040, 16'h3F80, 16'h4000);
      push(1, FP_ALU_SUB, 16'h4040, 16'h3F80, 16'h4000);
    end
    step(2);
    chk_reset();
    rst_ni = 1'b1;
    wait_drain(300, 0);
    check("n_grants", glog.size(), 8);
    for (int i = 0; i < 4 && i < glog.size(); i++) check("grant_order", glog[i], exp_ord[i]);

    // Directed add and multiply.
    push(0, FP_ALU_ADD, 16'h3F80, 16'h4000, 16'h4040);
    wait_drain(50, 0);
    push(1, FP_ALU_MUL, 16'h4000, 16'h4040, 16'h40C0);
    wait_drain(50, 0);

    // Response backpressure on req0 while req1 waits; rsp_ready[1] high must be ignored.
    rsp_ready = 2'b10;
    push(0, FP_ALU_MUL, 16'h4040, 16'h4040, 16'h4110);
    step(2);
    push(1, FP_ALU_ADD, 16'h4000, 16'h4000, 16'h4080);
    t = 0;
    while (!rsp_valid[0] && t < 50) begin step(1); t++; end
    check("bp_rsp_seen", rsp_valid[0], 1'b1);
    step(5);
    rsp_ready = 2'b11;
    wait_drain(50, 0);

    // req1 held valid through a req0 operation.
    push(0, FP_ALU_SUB, 16'h4080, 16'h3F80, 16'h4040);
    step(2);
    push(1, FP_ALU_MUL, 16'h3FC0, 16'h4000, 16'h4040);
    wait_drain(50, 0);

    // Random operations with random response backpressure.
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 2))
        0: op = FP_ALU_ADD;
        1: op = FP_ALU_SUB;
        default: op = FP_ALU_MUL;
      endcase
      a = {1'($urandom), 8'($urandom_range(120, 134)), 7'($urandom)};
      b = {1'($urandom), 8'($urandom_range(120, 134)), 7'($urandom)};
      push($urandom_range(0, 1), op, a, b, fpu_ref(op, a, b));
      step($urandom_range(0, 3));
    end
    wait_drain(2000, 1);

    // Reset in the second EXEC cycle of a multiply.
    push(0, FP_ALU_MUL, 16'h4000, 16'h4000, 16'h4080);
    t = 0;
    while (!busy && t < 20) begin step(1); t++; end
    check("exec_seen", busy, 1'b1);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_reset();
    sb.delete();
    model_last = 1;
    step(2);
    rst_ni = 1'b1;
    step(6);
    glog.delete();
    push(0, FP_ALU_ADD, 16'h3F80, 16'h3F80, 16'h4000);
    push(1, FP_ALU_ADD, 16'h4000, 16'h4000, 16'h4080);
    wait_drain(100, 0);
    check("n_grants_rst", glog.size(), 2);
    if (glog.size() == 2) begin
      check("prio_after_rst0", glog[0], 0);
      check("prio_after_rst1", glog[1], 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
